// File: rtl/led_status_multi.sv
// Multi-channel status LED driver: per-channel OFF/ON/BLINK/EVENT modes with
// pulse stretching, a shared blink phase and a global PWM brightness gate.
module led_status_multi #(
  parameter int unsigned NUM_LEDS      = 8,
  parameter int unsigned TICK_DIV      = 40000,
  parameter int unsigned BLINK_TICKS   = 250,
  parameter int unsigned STRETCH_TICKS = 50,
  parameter int unsigned PWM_BITS      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*NUM_LEDS-1:0] mode,
  input  logic [NUM_LEDS-1:0]   event_strobe,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [NUM_LEDS-1:0]   led_driver
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_EVENT = 2'b11
  } led_mode_e;

  localparam int unsigned TICK_W    = $clog2(TICK_DIV);
  localparam int unsigned BLINK_W   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int unsigned STRETCH_W = $clog2(STRETCH_TICKS + 1);

  localparam logic [TICK_W-1:0]    TICK_LAST    = TICK_W'(TICK_DIV - 1);
  localparam logic [BLINK_W-1:0]   BLINK_LAST   = BLINK_W'(BLINK_TICKS - 1);
  localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(STRETCH_TICKS);

  logic [TICK_W-1:0]    tick_cnt;
  logic                 tick;
  logic [BLINK_W-1:0]   blink_cnt;
  logic                 blink_phase;
  logic [STRETCH_W-1:0] stretch_cnt [NUM_LEDS];
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic                 gate;
  logic [NUM_LEDS-1:0]  raw;

  assign tick = (tick_cnt == TICK_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its neighbours, matching the hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pwm_cnt     <= '0;
      led_driver  <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        stretch_cnt[i] <= '0;
      end
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      pwm_cnt  <= pwm_cnt + 1'b1;

      if (tick) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      // A fresh event outranks the tick decrement, so retriggers restart the
      // full duration even on a tick cycle.
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (event_strobe[i]) begin
          stretch_cnt[i] <= STRETCH_LOAD;
        end else if (tick && (stretch_cnt[i] != '0)) begin
          stretch_cnt[i] <= stretch_cnt[i] - 1'b1;
        end
      end

      led_driver <= raw & {NUM_LEDS{gate}};
    end
  end

  // All-ones is forced fully on; otherwise the duty would top out one step short.
  assign gate = (&brightness) | (pwm_cnt < brightness);

  // NOTE: raw gets a default before the loop so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (led_mode_e'(mode[2*i +: 2]))
        MODE_OFF:   raw[i] = 1'b0;
        MODE_ON:    raw[i] = 1'b1;
        MODE_BLINK: raw[i] = blink_phase;
        MODE_EVENT: raw[i] = (stretch_cnt[i] != '0);
        default:    raw[i] = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_status_multi.sv
// Self-checking bench for led_status_multi: an arithmetic model of elapsed
// cycles is compared every cycle, plus hand-derived literal expectations.
module tb_led_status_multi;

  localparam int NL = 4;
  localparam int TD = 4;
  localparam int BT = 3;
  localparam int ST = 2;
  localparam int PB = 2;

  logic            clk          = 1'b0;
  logic            reset        = 1'b1;
  logic [2*NL-1:0] mode         = 8'h55;
  logic [NL-1:0]   event_strobe = 4'hF;
  logic [PB-1:0]   brightness   = 2'd3;
  logic [NL-1:0]   led_driver;

  led_status_multi #(
    .NUM_LEDS(NL), .TICK_DIV(TD), .BLINK_TICKS(BT),
    .STRETCH_TICKS(ST), .PWM_BITS(PB)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .event_strobe(event_strobe),
    .brightness(brightness), .led_driver(led_driver)
  );

  always begin
    #12 clk = 1'b1;
    #13 clk = 1'b0;
  end

  int n_pass  = 0;
  int n_total = 0;

  // Model state: k = cycles since reset release, last_ev = cycle index of the
  // most recent event per channel (-1 if none since reset).
  int            k = 0;
  int            last_ev [NL];
  logic [NL-1:0] exp_led = '0;
  bit            model_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at k=%0d: got %0h, expected %0h", name, k, act, exp);
  endtask

  // Flash lit at cycle kk iff fewer than ST ticks have elapsed since the load.
  function automatic bit stretch_on(input int ch, input int kk);
    if (last_ev[ch] < 0) return 1'b0;
    return ((kk / TD) - ((last_ev[ch] + 1) / TD)) < ST;
  endfunction

  function automatic bit gate_on(input int kk, input int b);
    if (b == (1 << PB) - 1) return 1'b1;
    return (kk % (1 << PB)) < b;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      exp_led     = '0;
      k           = 0;
      model_valid = 1'b1;
      for (int i = 0; i < NL; i++) last_ev[i] = -1;
    end else begin
      for (int i = 0; i < NL; i++) begin
        bit r;
        case (mode[2*i +: 2])
          2'b00:   r = 1'b0;
          2'b01:   r = 1'b1;
          2'b10:   r = ((k / (BT * TD)) % 2) == 1;
          default: r = stretch_on(i, k);
        endcase
        exp_led[i] = r & gate_on(k, int'(brightness));
      end
      for (int i = 0; i < NL; i++) if (event_strobe[i]) last_ev[i] = k;
      k++;
    end
  end

  always @(negedge clk) begin
    if (model_valid) check("led_model", 32'(led_driver), 32'(exp_led));
  end

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // Pulse event on channel 0 during a cycle with k%TD == r; report led one
  // cycle after the load and the run length of the following flash.
  task automatic flash_len(input int r, output int pre, output int len);
    for (int g = 0; g < TD && (k % TD) != r; g++) @(negedge clk);
    event_strobe[0] = 1'b1;
    @(negedge clk);
    event_strobe[0] = 1'b0;
    check("stretch_load", 32'(dut.stretch_cnt[0]), ST);
    pre = int'(led_driver[0]);
    len = 0;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      if (led_driver[0]) len++;
      else break;
    end
    repeat (12) @(negedge clk);
  endtask

  int  e [3];
  int  ne;
  int  pre;
  int  len;
  int  cnt;
  logic [NL-1:0] prev;

  initial begin
    // Reset held with ON mode and events asserted.
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", 32'(led_driver), 0);
    end
    reset = 1'b0;
    event_strobe = '0;
    repeat (2) @(negedge clk);
    check("post_reset_on", 32'(led_driver), 4'hF);

    // Blink timing from reset release.
    mode = 8'b10101010;
    do_reset(2);
    e = '{-1, -1, -1};
    ne = 0;
    prev = led_driver;
    for (int m = 1; m <= 50; m++) begin
      @(negedge clk);
      if (led_driver != prev) begin
        if (ne < 3) e[ne] = m;
        ne++;
        prev = led_driver;
      end
    end
    check("blink_first_rise", e[0], 13);
    check("blink_fall", e[1], 25);
    check("blink_rise2", e[2], 37);

    // Event flash in both tick phases, including event on the tick cycle.
    mode = 8'b00000011;
    do_reset(1);
    repeat (4) @(negedge clk);
    flash_len(2, pre, len);
    check("flash_pre_r2", pre, 0);
    check("flash_len_r2", len, 5);
    flash_len(3, pre, len);
    check("flash_pre_tick", pre, 0);
    check("flash_len_tick", len, 8);
    flash_len(0, pre, len);
    check("flash_len_r0", len, 7);

    // Retrigger four cycles after the first event.
    for (int g = 0; g < TD && (k % TD) != 3; g++) @(negedge clk);
    event_strobe[0] = 1'b1;
    @(negedge clk);
    event_strobe[0] = 1'b0;
    repeat (3) @(negedge clk);
    event_strobe[0] = 1'b1;
    @(negedge clk);
    event_strobe[0] = 1'b0;
    len = 0;
    for (int g = 0; g < 20; g++) begin
      if (led_driver[0]) len++;
      else break;
      @(negedge clk);
    end
    check("retrigger_len", len, 9);
    repeat (12) @(negedge clk);

    // PWM duty with all channels ON.
    mode = 8'h55;
    for (int b = 0; b < 4; b++) begin
      brightness = PB'(b);
      cnt = 0;
      repeat (8) begin
        @(negedge clk);
        if (led_driver == 4'hF) cnt++;
      end
      check("pwm_duty", cnt, (b == 3) ? 8 : 2 * b);
    end

    // Mixed modes, then reset in the middle of a flash.
    mode = 8'b11100100;
    brightness = 2'd3;
    do_reset(1);
    repeat (40) begin
      @(negedge clk);
      event_strobe = ($urandom_range(0, 5) == 0) ? NL'($urandom) : '0;
    end
    event_strobe = 4'b1000;
    @(negedge clk);
    event_strobe = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_flash", 32'(led_driver), 0);
    reset = 1'b0;
    cnt = 0;
    for (int g = 1; g < 12; g++) begin
      @(negedge clk);
      if (led_driver != 4'b0010) cnt++;
    end
    check("no_flash_after_reset", cnt, 0);

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 19) == 0) brightness = PB'($urandom);
      event_strobe = ($urandom_range(0, 7) == 0) ? NL'($urandom) : '0;
      reset = ($urandom_range(0, 99) == 0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
